number_input_sequencer: RTL and testbench

//  Sequences a raw ASCII byte stream (one number per line) into packed 64-bit words

---
 rtl/number_input_sequencer_if.sv | 23 ++
 rtl/number_input_sequencer.sv | 139 +++++++++++++
 tb/tb_number_input_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/number_input_sequencer_if.sv
// Byte-stream input and packed-word output bundle for number_input_sequencer.
// master: the environment (upstream byte source plus downstream converter).
// slave:  the sequencer itself.
interface number_input_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_number;
  logic [7:0]  out_position;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_number, out_position
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_number, out_position
  );
endinterface

// File: rtl/number_input_sequencer.sv
// number_input_sequencer: packs ASCII digit lines into 64-bit byte-lane words.
// Digit k of a line lands in bits [8k+7:8k]; a terminator (or in_last) hands the
// word and its digit count to the converter over a valid/ready handshake.
// Lines with more than MAX_DIGITS digits are dropped.
// Optional feature: define NUMIN_ERR_COUNT_EN to add the err_count port, a
// 16-bit saturating count of dropped lines.
module number_input_sequencer #(
  parameter int         MAX_DIGITS = 8,
  parameter logic [7:0] TERM_CHAR  = 8'h0A
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef NUMIN_ERR_COUNT_EN
  output logic [15:0]             err_count,
`endif
  number_input_sequencer_if.slave bus
);

  typedef enum logic [1:0] {FILL, SKIP, EMIT} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [63:0] lanes_q, lanes_d;
  logic [63:0] number_q, number_d;
  logic [7:0]  pos_q, pos_d;
  logic        valid_q, valid_d;

  logic in_ready;
  logic accept;
  logic is_digit;
  logic is_term;

  assign in_ready = (state_q != EMIT);
  assign accept   = bus.in_valid && in_ready;
  assign is_digit = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
  assign is_term  = (bus.in_data == TERM_CHAR);

  // Next-state, lane and output-word computation.
  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    state_d  = state_q;
    count_d  = count_q;
    lanes_d  = lanes_q;
    number_d = number_q;
    pos_d    = pos_q;
    valid_d  = valid_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          if (is_digit && count_q < MAX_CNT) begin
            lanes_d[{count_q[2:0], 3'b000} +: 8] = bus.in_data;
            count_d = count_q + 4'd1;
          end
          if (is_digit && count_q == MAX_CNT) begin
            if (bus.in_last) begin
              // Overflow on the final byte: the line is dropped right away.
              count_d = 4'd0;
              lanes_d = '0;
            end else begin
              state_d = SKIP;
            end
          end else if ((is_term || bus.in_last) && count_d != 4'd0) begin
            number_d = lanes_d;
            pos_d    = {4'b0000, count_d};
            valid_d  = 1'b1;
            state_d  = EMIT;
          end
        end
      end
      SKIP: begin
        if (accept && (is_term || bus.in_last)) begin
          count_d = 4'd0;
          lanes_d = '0;
          state_d = FILL;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          count_d = 4'd0;
          lanes_d = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      count_q  <= 4'd0;
      // NOTE: the lanes are plain flops and are cleared so no stale digit
      // from an interrupted line can leak into the next word.
      lanes_q  <= '0;
      number_q <= '0;
      pos_q    <= 8'd0;
      valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register sees pre-edge values.
      state_q  <= state_d;
      count_q  <= count_d;
      lanes_q  <= lanes_d;
      number_q <= number_d;
      pos_q    <= pos_d;
      valid_q  <= valid_d;
    end
  end

`ifdef NUMIN_ERR_COUNT_EN
  logic [15:0] err_q;
  logic        drop;

  assign drop = accept &&
                (((state_q == SKIP) && (is_term || bus.in_last)) ||
                 ((state_q == FILL) && is_digit && (count_q == MAX_CNT) && bus.in_last));

  // Saturating count of dropped (overflowed) lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 16'd0;
    end else if (drop && err_q != 16'hFFFF) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`endif

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = valid_q;
  assign bus.out_number   = number_q;
  assign bus.out_position = pos_q;

endmodule

// File: tb/tb_number_input_sequencer.sv
// Self-checking bench for number_input_sequencer. A line-level model (queue of
// digits, pending word, drop count) predicts the outputs; a compare process
// checks them every cycle, and directed literals pin the model.
// Builds with or without NUMIN_ERR_COUNT_EN.
module tb_number_input_sequencer;
  localparam int         MAX_DIGITS = 8;
  localparam logic [7:0] TERM       = 8'h0A;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  number_input_sequencer_if bus();
`ifdef NUMIN_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  number_input_sequencer #(.MAX_DIGITS(MAX_DIGITS), .TERM_CHAR(TERM)) dut (
    .clk(clk),
    .rst(rst),
`ifdef NUMIN_ERR_COUNT_EN
    .err_count(err_count),
`endif
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Line-level model.
  logic [7:0]  digits[$];
  bit          overflow;
  bit          m_valid;
  logic [63:0] m_number;
  logic [7:0]  m_pos;
  int          m_err;
  bit          chk_en = 1'b0;

  task automatic model_reset();
    digits.delete();
    overflow = 1'b0;
    m_valid  = 1'b0;
    m_number = '0;
    m_pos    = 8'd0;
    m_err    = 0;
  endtask

  task automatic drop_line();
    overflow = 1'b0;
    digits.delete();
    if (m_err < 16'hFFFF) m_err++;
  endtask

  task automatic model_byte(input logic [7:0] d, input bit last);
    bit digit;
    bit term;
    digit = (d >= 8'h30) && (d <= 8'h39);
    term  = (d == TERM);
    if (overflow) begin
      if (term || last) drop_line();
    end else begin
      if (digit) begin
        if (digits.size() < MAX_DIGITS) digits.push_back(d);
        else overflow = 1'b1;
      end
      if (overflow) begin
        if (last) drop_line();
      end else if ((term || last) && digits.size() > 0) begin
        m_valid  = 1'b1;
        m_pos    = 8'(digits.size());
        m_number = '0;
        foreach (digits[k]) m_number[8*k +: 8] = digits[k];
        digits.delete();
      end
    end
  endtask

  // One clock: drive inputs, apply the edge to the model, return at negedge.
  task automatic cycle(input bit iv, input logic [7:0] d, input bit last,
                       input bit ordy, input bit r, output bit acc);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_last   = last;
    bus.out_ready = ordy;
    rst           = r;
    @(posedge clk);
    acc = 1'b0;
    if (r) begin
      model_reset();
    end else if (m_valid) begin
      if (ordy) m_valid = 1'b0;
    end else if (iv) begin
      acc = 1'b1;
      model_byte(d, last);
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy, input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, ordy, 1'b0, acc);
  endtask

  task automatic do_reset();
    bit acc;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
  endtask

  // Present each byte until accepted (bounded).
  task automatic send(input string s, input bit last_on_end, input bit ordy);
    for (int i = 0; i < s.len(); i++) begin
      bit acc;
      int guard;
      guard = 0;
      do begin
        cycle(1'b1, s[i], last_on_end && (i == s.len() - 1), ordy, 1'b0, acc);
        guard++;
      end while (!acc && guard < 50);
      if (!acc) check("send_timeout", 64'(acc), 64'd1);
    end
  endtask

  task automatic expect_word(input string name, input logic [63:0] num, input logic [7:0] pos);
    check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_number"}, bus.out_number, num);
    check({name, "_position"}, 64'(bus.out_position), 64'(pos));
    check({name, "_model_number"}, m_number, num);
    check({name, "_model_position"}, 64'(m_pos), 64'(pos));
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 64'(bus.in_ready), 64'(!m_valid));
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      if (m_valid) begin
        check("out_number", bus.out_number, m_number);
        check("out_position", 64'(bus.out_position), 64'(m_pos));
      end
`ifdef NUMIN_ERR_COUNT_EN
      check("err_count", 64'(err_count), 64'(m_err));
`endif
    end
  end

  initial begin
    bit acc;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    model_reset();
    do_reset();
    do_reset();
    chk_en = 1'b1;

    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_number", bus.out_number, 64'd0);
    check("reset_out_position", 64'(bus.out_position), 64'd0);
`ifdef NUMIN_ERR_COUNT_EN
    check("reset_err_count", 64'(err_count), 64'd0);
`endif

    // Basic line: out_valid the cycle after the terminator, one pulse.
    send("1969\n", 1'b0, 1'b1);
    expect_word("w1969", 64'h39_36_39_31, 8'd4);
    idle(1'b1, 1);
    check("w1969_one_pulse", 64'(bus.out_valid), 64'd0);

    // CR ignored.
    send("12\r\n", 1'b0, 1'b1);
    expect_word("w12", 64'h3231, 8'd2);
    idle(1'b1, 1);

    // Empty lines emit nothing.
    send("\n\n", 1'b0, 1'b1);
    check("empty_valid", 64'(bus.out_valid), 64'd0);
    check("empty_in_ready", 64'(bus.in_ready), 64'd1);

    // Overflowed line dropped, next line clean.
    send("123456789\n", 1'b0, 1'b1);
    check("ovf_valid", 64'(bus.out_valid), 64'd0);
`ifdef NUMIN_ERR_COUNT_EN
    check("ovf_err_count", 64'(err_count), 64'd1);
`endif
    send("7\n", 1'b0, 1'b1);
    expect_word("w7", 64'h37, 8'd1);
    idle(1'b1, 1);

    // Exactly MAX_DIGITS digits is accepted.
    send("12345678\n", 1'b0, 1'b1);
    expect_word("w8dig", 64'h38_37_36_35_34_33_32_31, 8'd8);
    idle(1'b1, 1);

    // Overflow on the in_last byte counts as a dropped line.
    send("123456789", 1'b1, 1'b1);
    check("last_ovf_valid", 64'(bus.out_valid), 64'd0);
`ifdef NUMIN_ERR_COUNT_EN
    check("last_ovf_err_count", 64'(err_count), 64'd2);
`endif
    send("5", 1'b1, 1'b1);
    expect_word("w5last", 64'h35, 8'd1);
    idle(1'b1, 1);

    // in_last flush with backpressure; a byte is held upstream during EMIT.
    send("100756", 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h39, 1'b0, 1'b0, 1'b0, acc);
    expect_word("w100756", 64'h36_35_37_30_30_31, 8'd6);
    check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    cycle(1'b1, 8'h39, 1'b0, 1'b1, 1'b0, acc);
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    send("9\n", 1'b0, 1'b1);
    expect_word("w9held", 64'h39, 8'd1);
    idle(1'b1, 1);

    // Reset mid-line discards partial digits.
    send("45", 1'b0, 1'b1);
    do_reset();
    send("8\n", 1'b0, 1'b1);
    expect_word("w8rst", 64'h38, 8'd1);
    idle(1'b1, 1);

    // Reset mid-EMIT discards the pending word.
    send("3\n", 1'b0, 1'b0);
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    do_reset();
    check("post_rst_valid", 64'(bus.out_valid), 64'd0);
    idle(1'b1, 3);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
